e1_tx_mf_sched: RTL
===================

// Module: e1_tx_mf_sched
// PURPOSE
// - Serves the E1 TX framer's fetch interface from a multiframe (MF) buffer memory: sequences MF slots
//   queued by software, reads one byte per framer request, returns slot completions.
// - Also sources the per-MF E-bits (remote CRC-error report) from RX CRC error pulses.
// PARAMETERS
// - SLOT_W    2     log2 of number of MF buffer slots; submission FIFO depth = 2**SLOT_W
// - IDLE_BYTE 8'hd5 fill byte used on underrun (only with E1_TX_SCHED_IDLE_FILL_EN)
// PORTS
// - clk            in   1   clock
// - rst            in   1   reset, asynchronous, active-high
// - fr_frame       in   4   framer fetch: frame number 0..15
// - fr_ts          in   5   framer fetch: timeslot 0..31
// - fr_mf_first    in   1   request is first of MF (frame 0, TS0)
// - fr_mf_last     in   1   request is last of MF (frame 15, TS31)
// - fr_req         in   1   one-cycle fetch request pulse
// - fr_data        out  8   byte for requested TS
// - fr_crc_e       out  2   E-bits for current MF
// - fr_rdy         out  1   fr_data valid
// - buf_addr       out  SLOT_W+9  {slot, frame, ts}
// - buf_re         out  1   memory read enable
// - buf_rdata      in   8   memory data, valid 1 cycle after buf_re
// - sub_slot       in   SLOT_W  slot index to queue
// - sub_valid      in   1   push request
// - sub_ready      out  1   FIFO not full
// - done_slot      out  SLOT_W  completed slot index
// - done_valid     out  1   one-cycle completion pulse
// - done_underrun  out  1   pulse: MF started with empty FIFO
// - rx_crc_err     in   2   pulses: RX CRC error in SMF [0]=I, [1]=II
// - ctrl_flush     in   1   sync: empty submission FIFO
// BEHAVIOUR
// - Reset: fr_data=8'hff, fr_crc_e=2'b11, fr_rdy=0, buf_re=0, buf_addr=0, sub_ready=1, done_*=0,
//   FIFO empty, state IDLE, E-bit accumulators cleared.
// - Submission FIFO: push on sub_valid&sub_ready; full -> sub_ready=0, push ignored.
//   Push and pop in same cycle allowed, including when full (pop frees the slot first: occupancy unchanged).
// - ctrl_flush: FIFO emptied in that cycle (a simultaneous push is dropped); current MF continues.
// - FSM: IDLE, ACTIVE, UNDER. State changes only on fr_req with fr_mf_first, which is evaluated in every state:
//   FIFO non-empty -> pop head into cur_slot, go ACTIVE; FIFO empty -> go UNDER, pulse done_underrun.
// - fr_req in IDLE without fr_mf_first: fr_rdy=0, no read; stays IDLE (startup mid-MF).
// - ACTIVE read pipeline:
//   - cycle T: fr_req -> buf_re=1, buf_addr={cur_slot,fr_frame,fr_ts} registered at T+1.
//   - T+2: fr_data<=buf_rdata, fr_rdy=1.
//   - fr_data/fr_rdy held until next fr_req result updates them; framer request spacing >=3 cycles.
// - UNDER: fr_rdy=0 from T+2 for every request of that MF; no memory reads.
// - Completion:
//   - fr_req with fr_mf_last in ACTIVE -> done_slot=cur_slot, done_valid pulse at T+2 (after last read issued);
//     FSM to IDLE.
//   - UNDER + fr_mf_last -> IDLE, no done pulse.
// - E-bits: acc[1:0] |= rx_crc_err each cycle; on fr_req&fr_mf_first: fr_crc_e<=~acc (1 = no error per G.704),
//   acc cleared; pulse in that same cycle counts toward next MF.
// - Address wrap: frame/ts taken from framer as-is; no internal counters beyond FIFO pointers (SLOT_W+1 bits,
//   wrap naturally).
// - Reset mid-MF: all state to reset values; resumes at next fr_mf_first.
// CONFIGURATION
// - E1_TX_SCHED_IDLE_FILL_EN defined:
//   - UNDER serves fr_rdy=1, fr_data=IDLE_BYTE for every request.
//   - done_underrun unchanged.
// - Not defined: UNDER serves fr_rdy=0 (framer substitutes 8'hff); IDLE_BYTE unused.
// TESTING
// - Push slot 1, run one MF (512 req), mem[addr]=addr[7:0] -> fr_data sequence matches, done_slot=1 once after
//   frame15/TS31.
// - No push before fr_mf_first -> done_underrun pulse, fr_rdy=0 all 512 req (0xd5/rdy=1 with IDLE_FILL_EN).
// - Push 4 slots (SLOT_W=2) -> sub_ready=0; 5th push ignored; push+pop same cycle keeps count=4.
// - rx_crc_err=2'b10 mid-MF -> next MF fr_crc_e=2'b01, following MF 2'b11.
// - ctrl_flush with 3 queued -> next fr_mf_first gives done_underrun; current MF still completes with done_valid.
// - rst asserted at frame 7 -> outputs to reset values; service resumes at next fr_mf_first.

Source files
------------

// File: rtl/e1_tx_mf_sched.sv
// E1 TX multiframe fetch scheduler: queues MF buffer slots, serves framer byte fetches, sources E-bits.
// Define E1_TX_SCHED_IDLE_FILL_EN to serve IDLE_BYTE with fr_rdy=1 while a multiframe is underrun.
module e1_tx_mf_sched #(
   parameter int unsigned SLOT_W    = 2,
   parameter logic [7:0]  IDLE_BYTE = 8'hd5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [3:0]        fr_frame,
   input  logic [4:0]        fr_ts,
   input  logic              fr_mf_first,
   input  logic              fr_mf_last,
   input  logic              fr_req,
   output logic [7:0]        fr_data,
   output logic [1:0]        fr_crc_e,
   output logic              fr_rdy,
   output logic [SLOT_W+8:0] buf_addr,
   output logic              buf_re,
   input  logic [7:0]        buf_rdata,
   input  logic [SLOT_W-1:0] sub_slot,
   input  logic              sub_valid,
   output logic              sub_ready,
   output logic [SLOT_W-1:0] done_slot,
   output logic              done_valid,
   output logic              done_underrun,
   input  logic [1:0]        rx_crc_err,
   input  logic              ctrl_flush
);

`ifdef E1_TX_SCHED_IDLE_FILL_EN
   localparam logic FILL_EN = 1'b1;
`else
   localparam logic FILL_EN = 1'b0;
`endif

   localparam int unsigned DEPTH   = 1 << SLOT_W;
   localparam logic [SLOT_W:0] PTR_ONE = {{SLOT_W{1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_UNDER  = 2'd2
   } state_e;

   state_e              state_q, state_d;
   logic [SLOT_W-1:0]   cur_slot_q, cur_slot_d;
   logic [SLOT_W-1:0]   fifo_q [DEPTH];
   logic [SLOT_W:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic                fifo_empty_s, fifo_full_s, push_s, pop_s, mf_start_s;
   logic [SLOT_W-1:0]   head_slot_s, serve_slot_s;
   logic                serve_mem_s, serve_under_s, underrun_s;

   logic                buf_re_q, s1_under_q, s1_last_q, s2_mem_q, s2_under_q;
   logic [SLOT_W+8:0]   buf_addr_q;
   logic                done_valid_q, done_underrun_q;
   logic [SLOT_W-1:0]   done_slot_q;
   logic [7:0]          fr_data_q, fr_data_d;
   logic                fr_rdy_q, fr_rdy_d;
   logic [1:0]          acc_q, crc_e_q;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign fifo_empty_s = (wr_ptr_q == rd_ptr_q);
   assign fifo_full_s  = (wr_ptr_q[SLOT_W] != rd_ptr_q[SLOT_W]) &&
                         (wr_ptr_q[SLOT_W-1:0] == rd_ptr_q[SLOT_W-1:0]);
   assign head_slot_s  = fifo_q[rd_ptr_q[SLOT_W-1:0]];
   assign mf_start_s   = fr_req & fr_mf_first;
   assign pop_s        = mf_start_s & ~fifo_empty_s;
   assign push_s       = sub_valid & ~ctrl_flush & (~fifo_full_s | pop_s);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (ctrl_flush) begin
         rd_ptr_d = wr_ptr_q;
      end else begin
         if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
         end else begin
            rd_ptr_d = rd_ptr_q;
         end
         if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            fifo_q[i] <= '0;
         end
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         if (push_s) begin
            fifo_q[wr_ptr_q[SLOT_W-1:0]] <= sub_slot;
         end
      end
   end

   // A multiframe start is decided in every state; other requests are served per current state.
   always_comb begin
      state_d       = state_q;
      cur_slot_d    = cur_slot_q;
      serve_mem_s   = 1'b0;
      serve_under_s = 1'b0;
      serve_slot_s  = cur_slot_q;
      underrun_s    = 1'b0;
      if (mf_start_s) begin
         if (fifo_empty_s) begin
            state_d       = ST_UNDER;
            serve_under_s = 1'b1;
            underrun_s    = 1'b1;
         end else begin
            state_d      = ST_ACTIVE;
            cur_slot_d   = head_slot_s;
            serve_mem_s  = 1'b1;
            serve_slot_s = head_slot_s;
         end
      end else if (fr_req) begin
         case (state_q)
            ST_ACTIVE: begin
               serve_mem_s = 1'b1;
               state_d     = fr_mf_last ? ST_IDLE : ST_ACTIVE;
            end
            ST_UNDER: begin
               serve_under_s = 1'b1;
               state_d       = fr_mf_last ? ST_IDLE : ST_UNDER;
            end
            ST_IDLE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
         endcase
      end else begin
         state_d = state_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         cur_slot_q <= '0;
      end else begin
         state_q    <= state_d;
         cur_slot_q <= cur_slot_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         buf_re_q        <= 1'b0;
         buf_addr_q      <= '0;
         s1_under_q      <= 1'b0;
         s1_last_q       <= 1'b0;
         s2_mem_q        <= 1'b0;
         s2_under_q      <= 1'b0;
         done_valid_q    <= 1'b0;
         done_slot_q     <= '0;
         done_underrun_q <= 1'b0;
      end else begin
         buf_re_q <= serve_mem_s;
         if (serve_mem_s) begin
            buf_addr_q <= {serve_slot_s, fr_frame, fr_ts};
         end
         s1_under_q      <= serve_under_s;
         s1_last_q       <= serve_mem_s & fr_mf_last;
         s2_mem_q        <= buf_re_q;
         s2_under_q      <= s1_under_q;
         done_valid_q    <= buf_re_q & s1_last_q;
         // The slot index rides in the top bits of the read address of the last byte.
         if (buf_re_q & s1_last_q) begin
            done_slot_q <= buf_addr_q[SLOT_W+8:9];
         end
         done_underrun_q <= underrun_s;
      end
   end

   always_comb begin
      fr_data_d = fr_data_q;
      fr_rdy_d  = fr_rdy_q;
      if (s2_mem_q) begin
         fr_data_d = buf_rdata;
         fr_rdy_d  = 1'b1;
      end else if (s2_under_q) begin
         fr_rdy_d  = FILL_EN;
         fr_data_d = FILL_EN ? IDLE_BYTE : fr_data_q;
      end else begin
         fr_data_d = fr_data_q;
         fr_rdy_d  = fr_rdy_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fr_data_q <= 8'hff;
         fr_rdy_q  <= 1'b0;
      end else begin
         fr_data_q <= fr_data_d;
         fr_rdy_q  <= fr_rdy_d;
      end
   end

   // An error pulse coinciding with the MF start belongs to the new multiframe.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q   <= 2'b00;
         crc_e_q <= 2'b11;
      end else if (mf_start_s) begin
         crc_e_q <= ~acc_q;
         acc_q   <= rx_crc_err;
      end else begin
         acc_q   <= acc_q | rx_crc_err;
      end
   end

   assign fr_data       = fr_data_q;
   assign fr_rdy        = fr_rdy_q;
   assign fr_crc_e      = crc_e_q;
   assign buf_re        = buf_re_q;
   assign buf_addr      = buf_addr_q;
   assign sub_ready     = ~fifo_full_s;
   assign done_slot     = done_slot_q;
   assign done_valid    = done_valid_q;
   assign done_underrun = done_underrun_q;

endmodule
